// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter producing one-hot tri-state driver enables with a bounded
// grant length and an all-off turnaround gap between bus owners.
module tri_bus_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [N-1:0]         iReq,
  output logic [N-1:0]         oEna,
  output logic [$clog2(N)-1:0] oGntId,
  output logic                 oBusy,
  output logic                 oTimeout
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW  = $clog2(TURN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]     r_state;
  logic [N-1:0]   r_ena;
  logic [IDW-1:0] r_gnt_id;
  logic           r_busy;
  logic           r_timeout;
  logic [HW-1:0]  r_hold;
  logic [TW-1:0]  r_turn;
  logic [IDW-1:0] r_ptr;

  logic [1:0]     w_state_nxt;
  logic [N-1:0]   w_ena_nxt;
  logic [IDW-1:0] w_gnt_id_nxt;
  logic           w_busy_nxt;
  logic           w_timeout_nxt;
  logic [HW-1:0]  w_hold_nxt;
  logic [TW-1:0]  w_turn_nxt;
  logic [IDW-1:0] w_ptr_nxt;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic           w_do_grant;

  // First requester found scanning upward from the round-robin pointer.
  function automatic logic [IDW:0] f_pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] idx;
    logic           found;
    logic [IDW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    {w_found, w_win} = f_pick(iReq, r_ptr);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= S_IDLE;
      r_ena     <= '0;
      r_gnt_id  <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= '0;
      r_turn    <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ena     <= w_ena_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_hold    <= w_hold_nxt;
      r_turn    <= w_turn_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ena_nxt     = r_ena;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    w_turn_nxt    = r_turn;
    w_ptr_nxt     = r_ptr;
    w_do_grant    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_do_grant = w_found;
      end
      S_GRANT: begin
        // Voluntary release wins over the hold limit, so no timeout pulse then.
        if (!iReq[r_gnt_id]) begin
          w_ena_nxt   = '0;
          w_turn_nxt  = TW'(1);
          w_state_nxt = S_TURN;
        end else if (r_hold == HW'(MAX_HOLD)) begin
          w_ena_nxt     = '0;
          w_timeout_nxt = 1'b1;
          w_turn_nxt    = TW'(1);
          w_state_nxt   = S_TURN;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      S_TURN: begin
        if (r_turn == TW'(TURN_CYCLES)) begin
          if (w_found) begin
            w_do_grant = 1'b1;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_turn_nxt = r_turn + TW'(1);
        end
      end
      default: begin
        w_ena_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_do_grant) begin
      w_state_nxt  = S_GRANT;
      w_ena_nxt    = N'(1) << w_win;
      w_gnt_id_nxt = w_win;
      w_busy_nxt   = 1'b1;
      w_hold_nxt   = HW'(1);
      w_ptr_nxt    = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
    end
  end

  assign oEna     = r_ena;
  assign oGntId   = r_gnt_id;
  assign oBusy    = r_busy;
  assign oTimeout = r_timeout;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed plus randomized bench for tri_bus_arbiter, checked against an
// owner/length/gap reference model and bus-safety invariants.
`timescale 1ns/1ps
module tb_tri_bus_arbiter;

  localparam int N           = 4;
  localparam int MAX_HOLD    = 8;
  localparam int TURN_CYCLES = 1;

  logic         iClk;
  logic         iRst_n;
  logic [N-1:0] iReq;
  logic [N-1:0] oEna;
  logic [1:0]   oGntId;
  logic         oBusy;
  logic         oTimeout;

  int n_vec;
  int n_err;

  // Reference model: who owns the bus, for how long, and remaining gap.
  int m_owner;
  int m_len;
  int m_gap;
  int m_ptr;
  int m_gnt;
  bit m_busy;
  bit m_to;

  logic [N-1:0] prev_ena;
  logic         prev_to;
  int           run_len;

  tri_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iReq    (iReq),
    .oEna    (oEna),
    .oGntId  (oGntId),
    .oBusy   (oBusy),
    .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_len    = 0;
    m_gap    = 0;
    m_ptr    = 0;
    m_gnt    = 0;
    m_busy   = 1'b0;
    m_to     = 1'b0;
    prev_ena = '0;
    prev_to  = 1'b0;
    run_len  = 0;
  endtask

  task automatic model_grant(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req[k]) begin
        m_owner = k;
        m_gnt   = k;
        m_len   = 1;
        m_ptr   = (k + 1) % N;
        m_busy  = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_edge(input logic [N-1:0] req);
    m_to = 1'b0;
    if (!iRst_n) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = TURN_CYCLES;
      end else if (m_len == MAX_HOLD) begin
        m_owner = -1;
        m_gap   = TURN_CYCLES;
        m_to    = 1'b1;
      end else begin
        m_len++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (req != 0) model_grant(req);
        else m_busy = 1'b0;
      end
    end else if (req != 0) begin
      model_grant(req);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_ena;
    exp_ena = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk("ena", 32'(oEna), 32'(exp_ena));
    chk("gnt_id", 32'(oGntId), 32'(m_gnt));
    chk("busy", 32'(oBusy), 32'(m_busy));
    chk("timeout", 32'(oTimeout), 32'(m_to));
    chk("onehot", 32'($countones(oEna) <= 1), 32'(1));
    chk("no_adjacent_owners", 32'(!(prev_ena != 0 && oEna != 0 && prev_ena != oEna)), 32'(1));
    chk("timeout_single", 32'(!(prev_to && oTimeout)), 32'(1));
    run_len = (oEna != 0) ? run_len + 1 : 0;
    chk("hold_limit", 32'(run_len <= MAX_HOLD), 32'(1));
    prev_ena = oEna;
    prev_to  = oTimeout;
  endtask

  task automatic step(input logic [N-1:0] req);
    @(negedge iClk);
    iReq = req;
    @(posedge iClk);
    model_edge(req);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] r;
    n_vec  = 0;
    n_err  = 0;
    iRst_n = 1'b0;
    iReq   = 4'b1111;
    model_reset();

    // Reset held with everyone requesting.
    repeat (3) step(4'b1111);
    iRst_n = 1'b1;

    // Single request from index 2 for three edges.
    repeat (3) step(4'b0100);
    chk("single_gnt", 32'(oGntId), 32'(2));
    step(4'b0000);
    step(4'b0000);
    chk("single_idle", 32'(oBusy), 32'(0));

    // Saturation: rotating full-length grants.
    repeat (45) step(4'b1111);
    repeat (3) step(4'b0000);

    // Round robin wrap after serving index 2.
    iRst_n = 1'b0;
    step(4'b0000);
    iRst_n = 1'b1;
    repeat (2) step(4'b0100);
    repeat (2) step(4'b0000);
    step(4'b0101);
    chk("rr_wrap", 32'(oGntId), 32'(0));
    repeat (9) step(4'b0101);
    chk("rr_next", 32'(oGntId), 32'(2));
    repeat (3) step(4'b0000);

    // Asynchronous reset between edges while index 1 owns the bus.
    repeat (3) step(4'b0010);
    chk("pre_reset_ena", 32'(oEna), 32'(4'b0010));
    #2;
    iRst_n = 1'b0;
    #1;
    chk("async_ena", 32'(oEna), 32'(0));
    chk("async_busy", 32'(oBusy), 32'(0));
    #0.5;
    iRst_n = 1'b1;
    model_reset();
    step(4'b1001);
    chk("post_reset_gnt", 32'(oGntId), 32'(0));

    // Randomized request patterns with per-bit toggling.
    r = 4'b1001;
    repeat (300) begin
      r = r ^ (4'($urandom) & 4'($urandom));
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

- Round-robin arbiter and enable generator for a shared tri-state bus of N drivers.
- Each requester drives the bus through its own `three_state_gates` instance.
- This block produces those instances' `iEna` signals, one-hot.
- It enforces a maximum grant length and an all-off turnaround gap between owners, so two drivers never overlap on the bus.

## Interface

Parameters:
- `N`, default 4: number of requesters / tri-state drivers (2..16).
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last (≥1).
- `TURN_CYCLES`, default 1: all-off turnaround cycles after every grant (≥1).

Ports:
- `iClk`, input, 1: clock; all state changes on its rising edge.
- `iRst_n`, input, 1: asynchronous, active-low reset.
- `iReq`, input, N: request vector; bit k held high while requester k wants the bus.
- `oEna`, output, N: one-hot (or zero) driver enables; bit k drives `iEna` of gate k.
- `oGntId`, output, clog2(N): index of the current/last owner.
- `oBusy`, output, 1: high while in GRANT or TURN.
- `oTimeout`, output, 1: one-cycle pulse when a grant is ended by `MAX_HOLD`.

## Operation

- FSM states: IDLE, GRANT, TURN. All outputs are registered.
- Reset values: state = IDLE, `oEna` = 0, `oGntId` = 0, `oBusy` = 0, `oTimeout` = 0, hold counter = 0, turn counter = 0, RR pointer = 0.
- Arbitration picks a winner from sampled `iReq`.
  - Round robin starts at index ptr and wraps modulo N.
  - ptr = (last winner + 1) mod N, so after reset index 0 has highest priority.
- IDLE:
  - If `iReq` != 0 at an edge: arbitrate, set `oEna` = onehot(w), `oGntId` = w, `oBusy` = 1, hold counter = 1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, checked at each edge:
  - If `iReq[w]` = 0: `oEna` = 0, go to TURN. The release cause is voluntary.
  - Else if hold counter = `MAX_HOLD`: `oEna` = 0, `oTimeout` = 1 for exactly this cycle, go to TURN.
  - Else: hold counter +1, keep `oEna`.
  - Voluntary release takes precedence when both conditions hold; `oTimeout` stays 0 in that case.
  - Requests from other indices never preempt the owner.
- TURN:
  - `oEna` = 0 for exactly `TURN_CYCLES` cycles; the bus floats (Z).
  - At the edge ending the last TURN cycle: if `iReq` != 0, arbitrate and go directly to GRANT; else go to IDLE with `oBusy` = 0.
- The owner may immediately re-win after TURN only if no other index at or after ptr is requesting (normal RR rule).
- `iReq` changes during TURN are honoured at the arbitration edge only.
- Invariants:
  - `popcount(oEna)` ≤ 1 in every cycle.
  - Between two different consecutive non-zero `oEna` values there are at least `TURN_CYCLES` cycles of `oEna` = 0. The same applies when the owner repeats.
- Asynchronous reset in any state: `oEna` clears immediately, without waiting for a clock edge. All state returns to reset values, including ptr.

## Timing

- Request-to-enable latency is 1 edge: `iReq` is sampled high at edge t and `oEna` is valid after edge t.
- Maximum enable length is `MAX_HOLD` cycles.
- Release latency is 1 edge: `iReq[w]` sampled low at edge t gives `oEna` = 0 after edge t.
- Minimum handover gap is `TURN_CYCLES` cycles.
- Worst-case wait for a continuously requesting index: (N−1)·(`MAX_HOLD` + `TURN_CYCLES`) cycles.
- `oTimeout` coincides with the first TURN cycle.

## Test plan

All scenarios use N = 4, `MAX_HOLD` = 8, `TURN_CYCLES` = 1.

- **Reset:** `iRst_n` = 0, `iReq` = 1111, clock running → `oEna` = 0000, `oGntId` = 0, `oBusy` = 0, `oTimeout` = 0 throughout.
- **Single request:** `iReq` = 0100 sampled at edge 1, dropped and sampled low at edge 4 → `oEna` = 0100 for edges 1–3 (3 cycles) with `oGntId` = 2. Then `oEna` = 0000 from edge 4 and one TURN cycle. IDLE after edge 5 with `oBusy` = 0.
- **Saturation:** `iReq` = 1111 held continuously →
  - Grants go 0, 1, 2, 3, 0 …, each exactly 8 cycles, separated by exactly 1 zero cycle.
  - `oTimeout` pulses once per handover.
- **Round robin:** after index 2 is served, `iReq` = 0101 → index 0 wins (ptr = 3, wrap). Its next grant goes to index 2 if both are still requesting.
- **Async reset mid-grant:** during a grant with `oEna` = 0010, pulse `iRst_n` low between edges → `oEna` = 0000 before the next edge. After release, `iReq` = 1001 → index 0 wins.
- **Continuous assertions on all runs:** `popcount(oEna)` ≤ 1; no two distinct grants are adjacent without a zero cycle; `oTimeout` is never high for 2 consecutive cycles.
